// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the datapath: latches one 16-bit instruction on start
// and walks a Moore FSM through read, execute and write-back control cycles.
module datapath_ctrl #(
   parameter bit SXT_IMM = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] instr,
   output logic        waiting,
   output logic        illegal,
   output logic [15:0] datapath_in,
   output logic        wb_sel,
   output logic [2:0]  w_addr,
   output logic        w_en,
   output logic [2:0]  r_addr,
   output logic        en_A,
   output logic        en_B,
   output logic [1:0]  shift_op,
   output logic        sel_A,
   output logic        sel_B,
   output logic [1:0]  ALU_op,
   output logic        en_C,
   output logic        en_status
);

   typedef enum logic [2:0] {
      S_WAIT, S_WRIMM, S_LOADA, S_LOADB, S_EXEC, S_WRREG, S_ILL
   } state_t;

   state_t      state, state_nx, first_st;
   logic [15:0] ir;

   logic [2:0] opc, rn, rd, rm;
   logic [1:0] op;
   logic       is_cmp, is_mvn, is_movr;

   assign opc = ir[15:13];
   assign op  = ir[12:11];
   assign rn  = ir[10:8];
   assign rd  = ir[7:5];
   assign rm  = ir[2:0];

   assign is_cmp  = (opc == 3'b101) && (op == 2'b01);
   assign is_mvn  = (opc == 3'b101) && (op == 2'b11);
   assign is_movr = (opc == 3'b110) && (op == 2'b00);

   assign shift_op    = ir[4:3];
   assign datapath_in = SXT_IMM ? {{8{ir[7]}}, ir[7:0]} : {8'h00, ir[7:0]};

   // Entry state is decoded from the incoming instruction, not IR, so no decode cycle is spent.
   always_comb begin
      first_st = S_ILL;
      if (instr[15:13] == 3'b110) begin
         if (instr[12:11] == 2'b10)      first_st = S_WRIMM;
         else if (instr[12:11] == 2'b00) first_st = S_LOADB;
      end else if (instr[15:13] == 3'b101) begin
         first_st = (instr[12:11] == 2'b11) ? S_LOADB : S_LOADA;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_WAIT;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        ir <= 16'h0000;
      else if (state == S_WAIT && start) ir <= instr;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_WAIT:  state_nx = start ? first_st : S_WAIT;
         S_WRIMM: state_nx = S_WAIT;
         S_LOADA: state_nx = S_LOADB;
         S_LOADB: state_nx = S_EXEC;
         S_EXEC:  state_nx = is_cmp ? S_WAIT : S_WRREG;
         S_WRREG: state_nx = S_WAIT;
         S_ILL:   state_nx = S_WAIT;
         default: state_nx = S_WAIT;
      endcase
   end

   always_comb begin
      waiting   = 1'b0;
      illegal   = 1'b0;
      wb_sel    = 1'b0;
      w_addr    = 3'b000;
      w_en      = 1'b0;
      r_addr    = 3'b000;
      en_A      = 1'b0;
      en_B      = 1'b0;
      sel_A     = 1'b0;
      sel_B     = 1'b0;
      ALU_op    = 2'b00;
      en_C      = 1'b0;
      en_status = 1'b0;
      case (state)
         S_WAIT:  waiting = 1'b1;
         S_WRIMM: begin
            wb_sel = 1'b1;
            w_en   = 1'b1;
            w_addr = rn;
         end
         S_LOADA: begin
            r_addr = rn;
            en_A   = 1'b1;
         end
         S_LOADB: begin
            r_addr = rm;
            en_B   = 1'b1;
         end
         S_EXEC: begin
            // MOV-reg and MVN ignore A: add/not against a forced-zero A input.
            ALU_op    = is_movr ? 2'b00 : op;
            sel_A     = is_movr | is_mvn;
            en_C      = ~is_cmp;
            en_status = is_cmp;
         end
         S_WRREG: begin
            w_en   = 1'b1;
            w_addr = rd;
         end
         S_ILL:   illegal = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: per-instruction expected control traces are derived from
// the instruction fields and compared cycle by cycle against the DUT.
module tb_datapath_ctrl;

   typedef logic [35:0] vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] instr;

   logic        waiting, illegal, wb_sel, w_en, en_A, en_B, sel_A, sel_B, en_C, en_status;
   logic [15:0] datapath_in;
   logic [2:0]  w_addr, r_addr;
   logic [1:0]  shift_op, ALU_op;

   logic        z_waiting, z_illegal, z_wb_sel, z_w_en, z_en_A, z_en_B, z_sel_A, z_sel_B, z_en_C, z_en_status;
   logic [15:0] z_datapath_in;
   logic [2:0]  z_w_addr, z_r_addr;
   logic [1:0]  z_shift_op, z_ALU_op;

   int errors = 0;
   int checks = 0;
   vec_t exp_q[$];

   always #5 clk = ~clk;

   datapath_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
      .waiting(waiting), .illegal(illegal), .datapath_in(datapath_in),
      .wb_sel(wb_sel), .w_addr(w_addr), .w_en(w_en), .r_addr(r_addr),
      .en_A(en_A), .en_B(en_B), .shift_op(shift_op), .sel_A(sel_A),
      .sel_B(sel_B), .ALU_op(ALU_op), .en_C(en_C), .en_status(en_status)
   );

   datapath_ctrl #(.SXT_IMM(1'b0)) u_zxt (
      .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
      .waiting(z_waiting), .illegal(z_illegal), .datapath_in(z_datapath_in),
      .wb_sel(z_wb_sel), .w_addr(z_w_addr), .w_en(z_w_en), .r_addr(z_r_addr),
      .en_A(z_en_A), .en_B(z_en_B), .shift_op(z_shift_op), .sel_A(z_sel_A),
      .sel_B(z_sel_B), .ALU_op(z_ALU_op), .en_C(z_en_C), .en_status(z_en_status)
   );

   vec_t obs;
   assign obs = {waiting, illegal, wb_sel, w_addr, w_en, r_addr, en_A, en_B,
                 shift_op, sel_A, sel_B, ALU_op, en_C, en_status, datapath_in};

   function automatic vec_t mk(input int wt, il, wb, wa, we, ra, ea, eb, sa, alu, ec, es,
                               input logic [15:0] ir);
      return {wt[0], il[0], wb[0], wa[2:0], we[0], ra[2:0], ea[0], eb[0],
              ir[4:3], sa[0], 1'b0, alu[1:0], ec[0], es[0], {{8{ir[7]}}, ir[7:0]}};
   endfunction

   // Expected cycles after the capture edge, ending with the cycle back in wait.
   task automatic model(input logic [15:0] ir);
      int opc, op, rn, rd, rm;
      bit cmp, no_a, reg_cls;
      opc = int'(ir[15:13]); op = int'(ir[12:11]);
      rn = int'(ir[10:8]); rd = int'(ir[7:5]); rm = int'(ir[2:0]);
      cmp     = (opc == 5) && (op == 1);
      reg_cls = (opc == 5) || (opc == 6 && op == 0);
      no_a    = (opc == 6) || (op == 3);
      exp_q.delete();
      if (opc == 6 && op == 2) begin
         exp_q.push_back(mk(0, 0, 1, rn, 1, 0, 0, 0, 0, 0, 0, 0, ir));
      end else if (reg_cls) begin
         if (!no_a) exp_q.push_back(mk(0, 0, 0, 0, 0, rn, 1, 0, 0, 0, 0, 0, ir));
         exp_q.push_back(mk(0, 0, 0, 0, 0, rm, 0, 1, 0, 0, 0, 0, ir));
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, int'(no_a), (opc == 6) ? 0 : op,
                            int'(!cmp), int'(cmp), ir));
         if (!cmp) exp_q.push_back(mk(0, 0, 0, rd, 1, 0, 0, 0, 0, 0, 0, 0, ir));
      end else begin
         exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir));
      end
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir));
   endtask

   // Called on a falling edge; returns just after the capture edge.
   task automatic issue(input logic [15:0] i, input bit hold);
      start = 1'b1;
      instr = i;
      model(i);
      @(posedge clk);
      #1 start = hold;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; instr = 16'hFFFF;
      @(negedge clk);
      checks++;
      if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000)) begin
         errors++; $display("FAIL reset_state obs=%h exp=%h", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000));
      end
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000)) begin
            errors++; $display("FAIL idle_no_start c%0d obs=%h", k, obs);
         end
      end
      issue(16'hA148, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_q[k]) begin
            errors++; $display("FAIL rst_pre c%0d obs=%h exp=%h", k, obs, exp_q[k]);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000)) begin
         errors++; $display("FAIL async_reset obs=%h waiting=%b en_C=%b w_en=%b", obs, waiting, en_C, w_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000)) begin
            errors++; $display("FAIL post_reset_idle c%0d obs=%h", k, obs);
         end
      end
   endtask

   task automatic test_mov_imm();
      logic [15:0] prog [2];
      prog[0] = 16'hD009; prog[1] = 16'hD1F8;
      for (int p = 0; p < 2; p++) begin
         issue(prog[p], 1'b0);
         for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin
               errors++; $display("FAIL mov_imm%0d c%0d obs=%h exp=%h", p, k, obs, exp_q[k]);
            end
         end
         checks++;
         if (z_datapath_in !== {8'h00, prog[p][7:0]}) begin
            errors++; $display("FAIL zero_ext%0d got=%h want=%h", p, z_datapath_in, {8'h00, prog[p][7:0]});
         end
      end
      checks++;
      if (datapath_in !== 16'hFFF8) begin
         errors++; $display("FAIL sign_ext got=%h want=FFF8", datapath_in);
      end
   endtask

   task automatic test_alu();
      logic [15:0] prog [4];
      prog[0] = 16'hA148; prog[1] = 16'hA800; prog[2] = 16'hB860; prog[3] = 16'hC080;
      for (int p = 0; p < 4; p++) begin
         issue(prog[p], 1'b0);
         for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin
               errors++; $display("FAIL alu_%h c%0d obs=%h exp=%h", prog[p], k, obs, exp_q[k]);
            end
         end
      end
   endtask

   task automatic test_illegal();
      logic [15:0] prog [5];
      int pulses;
      prog[0] = 16'h0000; prog[1] = 16'hE123; prog[2] = 16'hC8FF;
      prog[3] = 16'hD8AA; prog[4] = 16'h9F01;
      for (int p = 0; p < 5; p++) begin
         issue(prog[p], 1'b0);
         pulses = 0;
         for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            pulses += int'(illegal);
            checks++;
            if (obs !== exp_q[k]) begin
               errors++; $display("FAIL illegal_%h c%0d obs=%h exp=%h", prog[p], k, obs, exp_q[k]);
            end
         end
         checks++;
         if (pulses != 1) begin
            errors++; $display("FAIL illegal_pulse_len got=%0d want=1", pulses);
         end
      end
   endtask

   task automatic test_start_ignored();
      issue(16'hA148, 1'b0);
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge clk);
         checks++;
         if (obs !== exp_q[k]) begin
            errors++; $display("FAIL busy_start c%0d obs=%h exp=%h", k, obs, exp_q[k]);
         end
         if (k < exp_q.size() - 1) begin
            start = 1'b1;
            instr = 16'hD7FF;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] prog [3];
      prog[0] = 16'hD305; prog[1] = 16'hAC97; prog[2] = 16'hD480;
      for (int p = 0; p < 3; p++) begin
         issue(prog[p], 1'b1);
         for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin
               errors++; $display("FAIL b2b%0d c%0d obs=%h exp=%h", p, k, obs, exp_q[k]);
            end
            if (k < exp_q.size() - 1) instr = 16'($urandom);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] i;
      int sel;
      for (int n = 0; n < 60; n++) begin
         i = 16'($urandom);
         sel = int'($urandom_range(0, 3));
         if (sel == 0)      i[15:13] = 3'b101;
         else if (sel == 1) i[15:13] = 3'b110;
         issue(i, 1'b0);
         for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_q[k]) begin
               errors++; $display("FAIL rand_%h c%0d obs=%h exp=%h", i, k, obs, exp_q[k]);
            end
            if (k < exp_q.size() - 1) begin
               start = 1'($urandom);
               instr = 16'($urandom);
            end
         end
      end
      start = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mov_imm();
      test_alu();
      test_illegal();
      test_start_ignored();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
Instruction sequencer that sits directly upstream of `datapath` and drives every one of its control inputs. It latches a 16-bit instruction on `start` and decodes it. It then steps a Moore FSM through the register-read, execute and write-back cycles needed to run the instruction on the datapath. `waiting` tells the instruction source when a new instruction may be issued.

Parameters:
SXT_IMM, 1, 1 = sign-extend imm8 onto `datapath_in`; 0 = zero-extend.

Ports:
clk  input  1  rising-edge clock shared with datapath
rst_n  input  1  asynchronous active-low reset
start  input  1  issue request; sampled only in S_WAIT
instr  input  16  instruction; captured on the clk edge where start=1 in S_WAIT
waiting  output  1  1 only in S_WAIT
illegal  output  1  one-cycle pulse: undefined opcode/op was latched
datapath_in  output  16  extended imm8 of the latched instruction, driven continuously
wb_sel  output  1  1 = write-back source is datapath_in; 0 = C register
w_addr  output  3  register-file write address
w_en  output  1  register-file write enable
r_addr  output  3  register-file read address
en_A  output  1  load A
en_B  output  1  load B
shift_op  output  2  shifter op; always latched instr[4:3]
sel_A  output  1  1 = ALU A input forced to 0
sel_B  output  1  constant 0
ALU_op  output  2  00 add, 01 sub, 10 and, 11 not-B
en_C  output  1  load C
en_status  output  1  load Z flag

Behaviour:
Encoding (latched instruction IR):
- Fields: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] imm8.
- 110/10 MOV Rn,#imm8
- 110/00 MOV Rd,Rm{,sh}
- 101/00 ADD Rd,Rn,Rm{,sh}
- 101/01 CMP Rn,Rm{,sh}
- 101/10 AND Rd,Rn,Rm{,sh}
- 101/11 MVN Rd,Rm{,sh}
- Anything else is illegal.

FSM states: S_WAIT, S_WRIMM, S_LOADA, S_LOADB, S_EXEC, S_WRREG, S_ILL. Outputs are Moore, decoded from state and IR only.

Default output values, in every state unless listed below, and during reset: all enables 0, wb_sel 0, sel_A 0, sel_B 0, ALU_op 00, r_addr 000, w_addr 000, illegal 0, waiting 0.

Per-state outputs:
- S_WAIT: waiting=1.
- S_WRIMM: wb_sel=1, w_en=1, w_addr=Rn.
- S_LOADA: r_addr=Rn, en_A=1.
- S_LOADB: r_addr=Rm, en_B=1.
- S_EXEC: ALU_op=op. For MOV-reg, ALU_op=00. sel_A=1 for MOV-reg and MVN. en_C=1, except CMP, which has en_C=0 and en_status=1.
- S_WRREG: wb_sel=0, w_en=1, w_addr=Rd.
- S_ILL: illegal=1.

Transitions:
- S_WAIT: if start=1, IR<=instr and go to the decoded first state; otherwise stay.
- MOV imm: WAIT→WRIMM→WAIT. Total 2 cycles from the start edge back to waiting.
- ADD/AND: WAIT→LOADA→LOADB→EXEC→WRREG→WAIT.
- CMP: WAIT→LOADA→LOADB→EXEC→WAIT.
- MOV-reg/MVN: WAIT→LOADB→EXEC→WRREG→WAIT (A is not loaded).
- Illegal: WAIT→ILL→WAIT.

Boundary rules:
- start is ignored outside S_WAIT.
- Changes on instr after capture have no effect; IR holds until the next capture.
- start held high issues back-to-back instructions. Each instruction begins on the edge leaving S_WAIT, so there is one S_WAIT cycle between instructions.
- rst_n low at any time: state→S_WAIT immediately (asynchronous), IR→0, all outputs at defaults with waiting=1. An in-flight instruction is abandoned; writes already performed remain.
- Rd=Rn or Rd=Rm is legal, because reads complete before write-back.
- imm8 extension:
  - SXT_IMM=1: datapath_in = {{8{imm8[7]}}, imm8}.
  - SXT_IMM=0: datapath_in = {8'h00, imm8}.

Test Plan:
1. rst_n=0 mid-S_EXEC of ADD → waiting=1, en_C=0, w_en=0 asynchronously. After release with start=0, the FSM stays in S_WAIT.
2. MOV R0,#9 (16'hD009) then MOV R1,#-8 (16'hD1F8) → one S_WRIMM cycle each with w_addr 0/1 and datapath_in 16'h0009/16'hFFF8. With SXT_IMM=0 the second gives 16'h00F8.
3. ADD R2,R1,R0,LSL#1 (16'hA148) → cycle sequence LOADA(r_addr=1)→LOADB(r_addr=0)→EXEC(shift_op=01, ALU_op=00, en_C=1)→WRREG(w_addr=2, wb_sel=0), then waiting. Mirrored into a real datapath, R2 = -8 + 18 = 10.
4. CMP R0,R0 (16'hA800) → EXEC has en_status=1, en_C=0; no WRREG state. With the datapath attached, Z_out=1.
5. MVN R3,R0 (16'hB860) and MOV R4,R0 (16'hC080) → no LOADA; EXEC has sel_A=1 with ALU_op 11 and 00 respectively. Written values are 16'hFFF6 and 16'h0009.
6. instr=16'h0000 with start=1 → illegal pulses for exactly 1 cycle, no enables asserted, then waiting=1. Also: start asserted during S_LOADB → ignored, and IR is unchanged.
